accel_frame_rotator: RTL and testbench

//  Sequential successor of the linear-transform top: rotates a signed 3-axis accelerometer sample by
//  one angle, given as Q(FRAC) sine/cosine, about a selectable axis (Z, Y, X) or passes it through.

---
 rtl/accel_frame_rotator.sv | 190 +++++++++++++++++++
 tb/tb_accel_frame_rotator.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/accel_frame_rotator.sv
// accel_frame_rotator
//   Rotates a signed 3-axis accelerometer sample about Z, Y or X by one angle
//   given as Q(FRAC) sine/cosine, or passes it through unchanged. A single
//   signed multiplier is shared across four product states. Operands are
//   captured on start, so the sample register upstream may change while busy.
//
//   state | meaning
//   IDLE  | waiting for enable; operands latched on the start edge
//   M0    | acc_a  = a*cos
//   M1    | acc_a -= b*sin
//   M2    | acc_b  = a*sin
//   M3    | acc_b += b*cos
//   WB    | round/fit accumulators, register outputs, pulse Done
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   enable             start request, only looked at in IDLE
//   mode               0: about Z, 1: about Y, 2: about X, 3: bypass
//   AcX/AcY/AcZ        signed input vector
//   sdseno/sdcoseno    signed Q(FRAC) sin/cos
//   XAc/YAc/ZAc        registered result, held until the next Done
//   Busy               high while a transform is in progress
//   Done               one-cycle pulse when results update
module accel_frame_rotator #(
  parameter int DATA_W   = 16,
  parameter int TRIG_W   = 16,
  parameter int FRAC     = 13,
  parameter int OUT_W    = 32,
  parameter bit SATURATE = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [1:0]               mode,
  input  logic signed [DATA_W-1:0] AcX,
  input  logic signed [DATA_W-1:0] AcY,
  input  logic signed [DATA_W-1:0] AcZ,
  input  logic signed [TRIG_W-1:0] sdseno,
  input  logic signed [TRIG_W-1:0] sdcoseno,
  output logic signed [OUT_W-1:0]  XAc,
  output logic signed [OUT_W-1:0]  YAc,
  output logic signed [OUT_W-1:0]  ZAc,
  output logic                     Busy,
  output logic                     Done
);

  localparam int PROD_W = DATA_W + TRIG_W;
  localparam int ACC_W  = PROD_W + 1;
  // One extra bit so adding the rounding constant can never wrap.
  localparam int SUM_W  = ACC_W + 1;
  localparam int RES_W  = SUM_W - FRAC;
  localparam logic signed [SUM_W-1:0] RND = SUM_W'(1) <<< (FRAC - 1);

  typedef enum logic [2:0] {S_IDLE, S_M0, S_M1, S_M2, S_M3, S_WB} state_t;

  state_t r_state, w_state_nxt;

  logic [1:0]               r_mode;
  logic signed [DATA_W-1:0] r_x, r_y, r_z;
  logic signed [TRIG_W-1:0] r_sin, r_cos;
  logic signed [ACC_W-1:0]  r_acc_a, r_acc_b;
  logic signed [OUT_W-1:0]  r_xac, r_yac, r_zac;
  logic                     r_done;

  logic                     w_start;
  logic signed [DATA_W-1:0] w_pa, w_pb, w_op_d;
  logic signed [TRIG_W-1:0] w_op_t;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [SUM_W-1:0]  w_sum_a, w_sum_b;
  logic signed [RES_W-1:0]  w_res_a, w_res_b;
  logic signed [OUT_W-1:0]  w_fit_a, w_fit_b;
  logic signed [OUT_W-1:0]  w_px, w_py, w_pz;

  assign w_start = (r_state == S_IDLE) && enable;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (enable) w_state_nxt = S_M0;
      S_M0:    w_state_nxt = S_M1;
      S_M1:    w_state_nxt = S_M2;
      S_M2:    w_state_nxt = S_M3;
      S_M3:    w_state_nxt = S_WB;
      S_WB:    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pair selection (a,b) and per-state multiplier operands.
  always_comb begin
    w_pa   = r_x;
    w_pb   = r_y;
    case (r_mode)
      2'd1:    begin w_pa = r_z; w_pb = r_x; end
      2'd2:    begin w_pa = r_y; w_pb = r_z; end
      default: begin w_pa = r_x; w_pb = r_y; end
    endcase
    w_op_d = w_pa;
    w_op_t = r_cos;
    case (r_state)
      S_M1:    begin w_op_d = w_pb; w_op_t = r_sin; end
      S_M2:    begin w_op_d = w_pa; w_op_t = r_sin; end
      S_M3:    begin w_op_d = w_pb; w_op_t = r_cos; end
      default: begin w_op_d = w_pa; w_op_t = r_cos; end
    endcase
  end

  assign w_prod  = w_op_d * w_op_t;

  // Round half up, then drop the fractional bits.
  assign w_sum_a = SUM_W'(r_acc_a) + RND;
  assign w_sum_b = SUM_W'(r_acc_b) + RND;
  assign w_res_a = w_sum_a[SUM_W-1:FRAC];
  assign w_res_b = w_sum_b[SUM_W-1:FRAC];

  generate
    if (RES_W <= OUT_W) begin : g_ext
      assign w_fit_a = OUT_W'(w_res_a);
      assign w_fit_b = OUT_W'(w_res_b);
    end else if (SATURATE) begin : g_sat
      localparam logic signed [OUT_W-1:0] MAXV = {1'b0, {(OUT_W-1){1'b1}}};
      localparam logic signed [OUT_W-1:0] MINV = {1'b1, {(OUT_W-1){1'b0}}};
      logic w_ovf_a, w_ovf_b;
      // In range only if every dropped bit matches the new sign bit.
      assign w_ovf_a = ~((&w_res_a[RES_W-1:OUT_W-1]) | ~(|w_res_a[RES_W-1:OUT_W-1]));
      assign w_ovf_b = ~((&w_res_b[RES_W-1:OUT_W-1]) | ~(|w_res_b[RES_W-1:OUT_W-1]));
      assign w_fit_a = w_ovf_a ? (w_res_a[RES_W-1] ? MINV : MAXV) : w_res_a[OUT_W-1:0];
      assign w_fit_b = w_ovf_b ? (w_res_b[RES_W-1] ? MINV : MAXV) : w_res_b[OUT_W-1:0];
    end else begin : g_wrap
      assign w_fit_a = w_res_a[OUT_W-1:0];
      assign w_fit_b = w_res_b[OUT_W-1:0];
    end
  endgenerate

  assign w_px = OUT_W'(r_x);
  assign w_py = OUT_W'(r_y);
  assign w_pz = OUT_W'(r_z);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_mode  <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_sin   <= '0;
      r_cos   <= '0;
      r_acc_a <= '0;
      r_acc_b <= '0;
      r_xac   <= '0;
      r_yac   <= '0;
      r_zac   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      if (w_start) begin
        r_mode <= mode;
        r_x    <= AcX;
        r_y    <= AcY;
        r_z    <= AcZ;
        r_sin  <= sdseno;
        r_cos  <= sdcoseno;
      end
      case (r_state)
        S_M0: r_acc_a <= ACC_W'(w_prod);
        S_M1: r_acc_a <= r_acc_a - ACC_W'(w_prod);
        S_M2: r_acc_b <= ACC_W'(w_prod);
        S_M3: r_acc_b <= r_acc_b + ACC_W'(w_prod);
        S_WB: begin
          r_done <= 1'b1;
          case (r_mode)
            2'd0:    begin r_xac <= w_fit_a; r_yac <= w_fit_b; r_zac <= w_pz;    end
            2'd1:    begin r_zac <= w_fit_a; r_xac <= w_fit_b; r_yac <= w_py;    end
            2'd2:    begin r_yac <= w_fit_a; r_zac <= w_fit_b; r_xac <= w_px;    end
            default: begin r_xac <= w_px;    r_yac <= w_py;    r_zac <= w_pz;    end
          endcase
        end
        default: ;
      endcase
    end
  end

  assign XAc  = r_xac;
  assign YAc  = r_yac;
  assign ZAc  = r_zac;
  assign Busy = (r_state != S_IDLE);
  assign Done = r_done;

endmodule

// File: tb/tb_accel_frame_rotator.sv
module tb_accel_frame_rotator;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic [1:0]         mode;
  logic signed [15:0] acx, acy, acz, sn, cs;

  logic signed [31:0] d_x, d_y, d_z;
  logic               d_busy, d_done;
  logic signed [15:0] s_x, s_y, s_z;
  logic               s_busy, s_done;
  logic signed [15:0] w_x, w_y, w_z;
  logic               w_busy, w_done;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  accel_frame_rotator dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode),
    .AcX(acx), .AcY(acy), .AcZ(acz), .sdseno(sn), .sdcoseno(cs),
    .XAc(d_x), .YAc(d_y), .ZAc(d_z), .Busy(d_busy), .Done(d_done)
  );

  accel_frame_rotator #(.OUT_W(16), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode),
    .AcX(acx), .AcY(acy), .AcZ(acz), .sdseno(sn), .sdcoseno(cs),
    .XAc(s_x), .YAc(s_y), .ZAc(s_z), .Busy(s_busy), .Done(s_done)
  );

  accel_frame_rotator #(.OUT_W(16), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode),
    .AcX(acx), .AcY(acy), .AcZ(acz), .sdseno(sn), .sdcoseno(cs),
    .XAc(w_x), .YAc(w_y), .ZAc(w_z), .Busy(w_busy), .Done(w_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  task automatic set_in(input logic [1:0] m, input int x, input int y, input int z,
                        input int s, input int c);
    mode = m;
    acx  = 16'(x);
    acy  = 16'(y);
    acz  = 16'(z);
    sn   = 16'(s);
    cs   = 16'(c);
  endtask

  // One-cycle enable pulse; returns just after the sampling edge.
  task automatic start();
    enable = 1'b1;
    tick();
    enable = 1'b0;
  endtask

  // Ticks until Done, counting cycles and Busy-high cycles; bounded.
  task automatic wait_done(output int cyc, output int nbusy);
    cyc   = 0;
    nbusy = 0;
    while (d_done !== 1'b1 && cyc < 20) begin
      if (d_busy === 1'b1) nbusy++;
      tick();
      cyc++;
    end
    chk("done_seen", 64'(d_done), 64'(1));
  endtask

  int cyc, nb, ndone;

  initial begin
    rst    = 1'b1;
    enable = 1'b0;
    set_in(2'd0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("rst_busy", 64'(d_busy), 64'(0));
    chk("rst_done", 64'(d_done), 64'(0));
    chk("rst_x", d_x, 0);
    chk("rst_y", d_y, 0);
    chk("rst_z", d_z, 0);
    rst = 1'b0;
    tick();

    // 1: small rotation about Z
    set_in(2'd0, 1000, 1000, 0, 144, 8191);
    start();
    chk("t1_busy_k1", 64'(d_busy), 64'(1));
    wait_done(cyc, nb);
    chk("t1_lat", 64'(cyc), 64'(5));
    chk("t1_busycnt", 64'(nb), 64'(5));
    chk("t1_busy_in_done", 64'(d_busy), 64'(0));
    chk("t1_x", d_x, 982);
    chk("t1_y", d_y, 1017);
    chk("t1_z", d_z, 0);
    tick();
    chk("t1_done_1cyc", 64'(d_done), 64'(0));
    chk("t1_hold_x", d_x, 982);

    // 2: identity with cos=1.0, negative input
    set_in(2'd0, -1000, 0, 7, 0, 8192);
    start();
    wait_done(cyc, nb);
    chk("t2_x", d_x, 64'hFFFF_FFFF_FFFF_FC18);
    chk("t2_y", d_y, 0);
    chk("t2_z", d_z, 7);

    // 3: 90 degrees about Y, then bypass
    set_in(2'd1, 0, 5, 2000, 8192, 0);
    start();
    wait_done(cyc, nb);
    chk("t3_x", d_x, 2000);
    chk("t3_y", d_y, 5);
    chk("t3_z", d_z, 0);
    set_in(2'd3, 0, 5, 2000, 8192, 0);
    start();
    wait_done(cyc, nb);
    chk("t3b_busycnt", 64'(nb), 64'(5));
    chk("t3b_x", d_x, 0);
    chk("t3b_y", d_y, 5);
    chk("t3b_z", d_z, 2000);

    // 4: overflow of a 16-bit output
    set_in(2'd0, 32767, 32767, 0, 8192, 8192);
    start();
    wait_done(cyc, nb);
    chk("t4_full_y", d_y, 65534);
    chk("t4_sat_x", s_x, 0);
    chk("t4_sat_y", s_y, 32767);
    chk("t4_wrap_x", w_x, 0);
    chk("t4_wrap_y", w_y, -2);

    // 5: enable while busy is ignored; back-to-back from the Done cycle
    set_in(2'd0, 1000, 1000, 0, 144, 8191);
    start();
    tick();
    enable = 1'b1;
    acx    = 16'sd5;
    tick();
    enable = 1'b0;
    wait_done(cyc, nb);
    chk("t5_lat", 64'(cyc + 2), 64'(5));
    chk("t5_x", d_x, 982);
    chk("t5_y", d_y, 1017);
    set_in(2'd0, 1000, 1000, 0, 144, 8191);
    start();
    ndone = 0;
    cyc   = 1;
    while (d_done !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("t5_period", 64'(cyc), 64'(6));
    chk("t5b_x", d_x, 982);

    // 6: reset aborts a transform
    set_in(2'd0, 1000, 1000, 0, 144, 8191);
    tick();
    start();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_busy", 64'(d_busy), 64'(0));
    chk("t6_done", 64'(d_done), 64'(0));
    chk("t6_x", d_x, 0);
    chk("t6_y", d_y, 0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (d_done === 1'b1) ndone++;
    end
    chk("t6_no_done", 64'(ndone), 64'(0));
    start();
    wait_done(cyc, nb);
    chk("t6_lat", 64'(cyc), 64'(5));
    chk("t6_x2", d_x, 982);
    chk("t6_y2", d_y, 1017);
    chk("t6_z2", d_z, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
